// File: rtl/enter_prompt_ctrl_pkg.sv
// Shared types and screen constants for the enter prompt controller and its
// rectangle hit-test helper.
package enter_prompt_pkg;

    typedef logic [10:0] coord_t;
    typedef logic [11:0] coord_ext_t;

    typedef enum logic [1:0] {
        HIDDEN    = 2'd0,
        SLIDE_IN  = 2'd1,
        BLINK_ON  = 2'd2,
        BLINK_OFF = 2'd3
    } prompt_state_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    // Widening to 12 bits keeps right/bottom edges and slide arithmetic from wrapping.
    function automatic coord_ext_t extend_coord(input coord_t c);
        return {1'b0, c};
    endfunction

endpackage

// File: rtl/enter_prompt_ctrl_if.sv
// Pixel/control bundle between the VGA/game side (master) and the prompt
// controller (slave).
interface enter_prompt_ctrl_if;
    import enter_prompt_pkg::*;

    coord_t pixelX;
    coord_t pixelY;
    logic   startOfFrame;
    logic   show;
    logic   enterPressed;
    coord_t offsetX;
    coord_t offsetY;
    logic   InsideRectangle;
    logic   promptActive;
    logic   enterAck;

    modport master (
        output pixelX, pixelY, startOfFrame, show, enterPressed,
        input  offsetX, offsetY, InsideRectangle, promptActive, enterAck
    );

    modport slave (
        input  pixelX, pixelY, startOfFrame, show, enterPressed,
        output offsetX, offsetY, InsideRectangle, promptActive, enterAck
    );
endinterface

// File: rtl/enter_prompt_ctrl_rect_hit_test.sv
// Combinational point-in-rectangle test with offsets relative to the top-left
// corner; offsets are zero whenever the point is outside.
module rect_hit_test
    import enter_prompt_pkg::*;
(
    input  coord_t pixelX,
    input  coord_t pixelY,
    input  coord_t rectX,
    input  coord_t rectY,
    input  coord_t rectW,
    input  coord_t rectH,
    output logic   hit,
    output coord_t offsetX,
    output coord_t offsetY
);

    coord_ext_t px, py, left_e, top_e, right_e, bottom_e;
    logic       in_x, in_y;

    always_comb begin
        px       = extend_coord(pixelX);
        py       = extend_coord(pixelY);
        left_e   = extend_coord(rectX);
        top_e    = extend_coord(rectY);
        right_e  = left_e + extend_coord(rectW);
        bottom_e = top_e + extend_coord(rectH);
        in_x     = (px >= left_e) && (px < right_e);
        in_y     = (py >= top_e) && (py < bottom_e);
        hit      = in_x && in_y;
        offsetX  = '0;
        offsetY  = '0;
        if (hit) begin
            offsetX = pixelX - rectX;
            offsetY = pixelY - rectY;
        end
    end

endmodule

// File: rtl/enter_prompt_ctrl.sv
// Places, slides in and blinks the "press enter" prompt and acknowledges Enter.
// Optional ENTER_PROMPT_SKIP_SLIDE_EN: Enter during the slide snaps to rest and blinks.
module enter_prompt_ctrl
    import enter_prompt_pkg::*;
#(
    parameter int OBJECT_WIDTH_X = 51,
    parameter int OBJECT_HEIGHT_Y = 15,
    parameter int TARGET_X       = 294,
    parameter int TARGET_Y       = 400,
    parameter int START_Y        = 480,
    parameter int SLIDE_STEP     = 2,
    parameter int BLINK_FRAMES   = 30
) (
    input  logic clk,
    input  logic reset,
    enter_prompt_ctrl_if.slave bus
);

    localparam int CNT_W = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;

    localparam coord_t     TARGET_X_C   = coord_t'(TARGET_X);
    localparam coord_t     TARGET_Y_C   = coord_t'(TARGET_Y);
    localparam coord_t     START_Y_C    = coord_t'(START_Y);
    localparam coord_t     WIDTH_C      = coord_t'(OBJECT_WIDTH_X);
    localparam coord_t     HEIGHT_C     = coord_t'(OBJECT_HEIGHT_Y);
    localparam coord_ext_t TARGET_Y_E   = coord_ext_t'(TARGET_Y);
    localparam coord_ext_t STEP_E       = coord_ext_t'(SLIDE_STEP);
    localparam coord_ext_t SCREEN_W_E   = coord_ext_t'(SCREEN_W);
    localparam coord_ext_t SCREEN_H_E   = coord_ext_t'(SCREEN_H);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    prompt_state_t    state_q, state_d;
    coord_t           top_y_q, top_y_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             enter_ack_q, enter_ack_d;
    logic             inside_q, inside_d;
    coord_t           offset_x_q, offset_x_d;
    coord_t           offset_y_q, offset_y_d;

    coord_ext_t       slide_next;
    logic             visible;
    logic             raw_hit;
    coord_t           raw_off_x, raw_off_y;

    // Clamped slide target: never steps past the rest row, even for odd distances.
    always_comb begin
        if (extend_coord(top_y_q) >= TARGET_Y_E + STEP_E)
            slide_next = extend_coord(top_y_q) - STEP_E;
        else
            slide_next = TARGET_Y_E;
    end

    // Frame-aligned animation; only Enter and a dropped show leave mid-frame.
    always_comb begin
        state_d     = state_q;
        top_y_d     = top_y_q;
        frame_cnt_d = frame_cnt_q;
        enter_ack_d = 1'b0;
        case (state_q)
            HIDDEN: begin
                if (bus.startOfFrame && bus.show) begin
                    state_d     = SLIDE_IN;
                    top_y_d     = START_Y_C;
                    frame_cnt_d = '0;
                end
            end
            SLIDE_IN: begin
                if (!bus.show) begin
                    state_d     = HIDDEN;
                    top_y_d     = START_Y_C;
                    frame_cnt_d = '0;
                end
`ifdef ENTER_PROMPT_SKIP_SLIDE_EN
                else if (bus.enterPressed) begin
                    state_d     = BLINK_ON;
                    top_y_d     = TARGET_Y_C;
                    frame_cnt_d = '0;
                end
`endif
                else if (bus.startOfFrame) begin
                    top_y_d = slide_next[10:0];
                    if (slide_next == TARGET_Y_E) begin
                        state_d     = BLINK_ON;
                        frame_cnt_d = '0;
                    end
                end
            end
            BLINK_ON, BLINK_OFF: begin
                if (bus.enterPressed || !bus.show) begin
                    state_d     = HIDDEN;
                    top_y_d     = START_Y_C;
                    frame_cnt_d = '0;
                    enter_ack_d = bus.enterPressed;
                end else if (bus.startOfFrame) begin
                    if (frame_cnt_q == CNT_LAST) begin
                        state_d     = (state_q == BLINK_ON) ? BLINK_OFF : BLINK_ON;
                        frame_cnt_d = '0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d     = HIDDEN;
                top_y_d     = START_Y_C;
                frame_cnt_d = '0;
            end
        endcase
    end

    rect_hit_test u_hit (
        .pixelX  (bus.pixelX),
        .pixelY  (bus.pixelY),
        .rectX   (TARGET_X_C),
        .rectY   (top_y_q),
        .rectW   (WIDTH_C),
        .rectH   (HEIGHT_C),
        .hit     (raw_hit),
        .offsetX (raw_off_x),
        .offsetY (raw_off_y)
    );

    // Pixels off the visible raster never hit, so a half-entered prompt clips cleanly.
    always_comb begin
        visible    = (state_q == SLIDE_IN) || (state_q == BLINK_ON);
        inside_d   = visible && raw_hit
                     && (extend_coord(bus.pixelX) < SCREEN_W_E)
                     && (extend_coord(bus.pixelY) < SCREEN_H_E);
        offset_x_d = inside_d ? raw_off_x : '0;
        offset_y_d = inside_d ? raw_off_y : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= HIDDEN;
            top_y_q     <= START_Y_C;
            frame_cnt_q <= '0;
            enter_ack_q <= 1'b0;
            inside_q    <= 1'b0;
            offset_x_q  <= '0;
            offset_y_q  <= '0;
        end else begin
            state_q     <= state_d;
            top_y_q     <= top_y_d;
            frame_cnt_q <= frame_cnt_d;
            enter_ack_q <= enter_ack_d;
            inside_q    <= inside_d;
            offset_x_q  <= offset_x_d;
            offset_y_q  <= offset_y_d;
        end
    end

    assign bus.InsideRectangle = inside_q;
    assign bus.offsetX         = offset_x_q;
    assign bus.offsetY         = offset_y_q;
    assign bus.enterAck        = enter_ack_q;
    assign bus.promptActive    = (state_q != HIDDEN);

endmodule

// File: tb/tb_enter_prompt_ctrl.sv
// Directed bench for enter_prompt_ctrl: slide, blink, Enter/show exits and reset.
module tb_enter_prompt_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    enter_prompt_ctrl_if bus ();

    enter_prompt_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame_pulse(input int n);
        for (int i = 0; i < n; i++) begin
            bus.startOfFrame = 1'b1;
            tick();
            bus.startOfFrame = 1'b0;
            tick();
        end
    endtask

    task automatic set_pixel(input int x, input int y);
        bus.pixelX = 11'(x);
        bus.pixelY = 11'(y);
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if (bus.InsideRectangle !== 1'b0 || bus.offsetX !== 11'd0 || bus.offsetY !== 11'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: inside=%b ox=%0d oy=%0d, expected 0/0/0",
                     bus.InsideRectangle, bus.offsetX, bus.offsetY);
        end
        checks++;
        if (bus.promptActive !== 1'b0 || bus.enterAck !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_status: active=%b ack=%b, expected 0/0",
                     bus.promptActive, bus.enterAck);
        end
        reset = 1'b0;
        set_pixel(294, 400);
        bus.enterPressed = 1'b1;
        tick();
        bus.enterPressed = 1'b0;
        checks++;
        if (bus.InsideRectangle !== 1'b0 || bus.promptActive !== 1'b0 || bus.enterAck !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hidden_idle: inside=%b active=%b ack=%b, expected 0/0/0",
                     bus.InsideRectangle, bus.promptActive, bus.enterAck);
        end
    endtask

    task automatic test_slide();
        bus.show = 1'b1;
        frame_pulse(1);
        set_pixel(294, 479);
        checks++;
        if (bus.promptActive !== 1'b1 || bus.InsideRectangle !== 1'b0) begin
            errors++;
            $display("[TB] FAIL slide_start: active=%b inside=%b, expected 1/0",
                     bus.promptActive, bus.InsideRectangle);
        end
        frame_pulse(5);
        set_pixel(294, 470);
        checks++;
        if (bus.InsideRectangle !== 1'b1 || bus.offsetX !== 11'd0 || bus.offsetY !== 11'd0) begin
            errors++;
            $display("[TB] FAIL slide_top470: inside=%b ox=%0d oy=%0d, expected 1/0/0",
                     bus.InsideRectangle, bus.offsetX, bus.offsetY);
        end
        set_pixel(294, 469);
        checks++;
        if (bus.InsideRectangle !== 1'b0) begin
            errors++;
            $display("[TB] FAIL slide_above469: inside=%b, expected 0", bus.InsideRectangle);
        end
        set_pixel(294, 482);
        checks++;
        if (bus.InsideRectangle !== 1'b0 || bus.offsetY !== 11'd0) begin
            errors++;
            $display("[TB] FAIL offscreen_row482: inside=%b oy=%0d, expected 0/0",
                     bus.InsideRectangle, bus.offsetY);
        end
        frame_pulse(34);
        set_pixel(300, 416);
        checks++;
        if (bus.InsideRectangle !== 1'b1 || bus.offsetX !== 11'd6 || bus.offsetY !== 11'd14) begin
            errors++;
            $display("[TB] FAIL slide_bottom402: inside=%b ox=%0d oy=%0d, expected 1/6/14",
                     bus.InsideRectangle, bus.offsetX, bus.offsetY);
        end
        set_pixel(300, 417);
        checks++;
        if (bus.InsideRectangle !== 1'b0) begin
            errors++;
            $display("[TB] FAIL slide_below417: inside=%b, expected 0", bus.InsideRectangle);
        end
        frame_pulse(1);
        set_pixel(294, 400);
        checks++;
        if (bus.InsideRectangle !== 1'b1 || bus.offsetX !== 11'd0 || bus.offsetY !== 11'd0) begin
            errors++;
            $display("[TB] FAIL rest_origin: inside=%b ox=%0d oy=%0d, expected 1/0/0",
                     bus.InsideRectangle, bus.offsetX, bus.offsetY);
        end
        set_pixel(345, 400);
        checks++;
        if (bus.InsideRectangle !== 1'b0 || bus.offsetX !== 11'd0) begin
            errors++;
            $display("[TB] FAIL rest_right345: inside=%b ox=%0d, expected 0/0",
                     bus.InsideRectangle, bus.offsetX);
        end
        set_pixel(344, 414);
        checks++;
        if (bus.InsideRectangle !== 1'b1 || bus.offsetX !== 11'd50 || bus.offsetY !== 11'd14) begin
            errors++;
            $display("[TB] FAIL rest_corner: inside=%b ox=%0d oy=%0d, expected 1/50/14",
                     bus.InsideRectangle, bus.offsetX, bus.offsetY);
        end
        set_pixel(293, 400);
        checks++;
        if (bus.InsideRectangle !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rest_left293: inside=%b, expected 0", bus.InsideRectangle);
        end
        set_pixel(294, 399);
        checks++;
        if (bus.InsideRectangle !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rest_above399: inside=%b, expected 0", bus.InsideRectangle);
        end
    endtask

    task automatic test_blink();
        set_pixel(300, 405);
        frame_pulse(29);
        checks++;
        if (bus.InsideRectangle !== 1'b1 || bus.offsetX !== 11'd6 || bus.offsetY !== 11'd5) begin
            errors++;
            $display("[TB] FAIL blink_on_29: inside=%b ox=%0d oy=%0d, expected 1/6/5",
                     bus.InsideRectangle, bus.offsetX, bus.offsetY);
        end
        frame_pulse(1);
        checks++;
        if (bus.InsideRectangle !== 1'b0 || bus.offsetX !== 11'd0 || bus.promptActive !== 1'b1) begin
            errors++;
            $display("[TB] FAIL blink_off_30: inside=%b ox=%0d active=%b, expected 0/0/1",
                     bus.InsideRectangle, bus.offsetX, bus.promptActive);
        end
        frame_pulse(29);
        checks++;
        if (bus.InsideRectangle !== 1'b0) begin
            errors++;
            $display("[TB] FAIL blink_off_59: inside=%b, expected 0", bus.InsideRectangle);
        end
        frame_pulse(1);
        checks++;
        if (bus.InsideRectangle !== 1'b1 || bus.offsetX !== 11'd6 || bus.offsetY !== 11'd5) begin
            errors++;
            $display("[TB] FAIL blink_on_60: inside=%b ox=%0d oy=%0d, expected 1/6/5",
                     bus.InsideRectangle, bus.offsetX, bus.offsetY);
        end
    endtask

    task automatic test_enter_blink_off();
        frame_pulse(30);
        checks++;
        if (bus.InsideRectangle !== 1'b0 || bus.enterAck !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pre_enter_off: inside=%b ack=%b, expected 0/0",
                     bus.InsideRectangle, bus.enterAck);
        end
        bus.enterPressed = 1'b1;
        tick();
        bus.enterPressed = 1'b0;
        checks++;
        if (bus.enterAck !== 1'b1 || bus.promptActive !== 1'b0) begin
            errors++;
            $display("[TB] FAIL enter_ack_rise: ack=%b active=%b, expected 1/0",
                     bus.enterAck, bus.promptActive);
        end
        tick();
        checks++;
        if (bus.enterAck !== 1'b0 || bus.promptActive !== 1'b0) begin
            errors++;
            $display("[TB] FAIL enter_ack_fall: ack=%b active=%b, expected 0/0",
                     bus.enterAck, bus.promptActive);
        end
    endtask

    task automatic test_enter_slide();
        frame_pulse(6);
        set_pixel(294, 470);
        bus.enterPressed = 1'b1;
        tick();
        bus.enterPressed = 1'b0;
        checks++;
        if (bus.enterAck !== 1'b0 || bus.promptActive !== 1'b1) begin
            errors++;
            $display("[TB] FAIL slide_enter_ack: ack=%b active=%b, expected 0/1",
                     bus.enterAck, bus.promptActive);
        end
`ifdef ENTER_PROMPT_SKIP_SLIDE_EN
        set_pixel(294, 400);
        checks++;
        if (bus.InsideRectangle !== 1'b1 || bus.offsetY !== 11'd0) begin
            errors++;
            $display("[TB] FAIL skip_snap400: inside=%b oy=%0d, expected 1/0",
                     bus.InsideRectangle, bus.offsetY);
        end
        frame_pulse(30);
        checks++;
        if (bus.InsideRectangle !== 1'b0) begin
            errors++;
            $display("[TB] FAIL skip_blink_off: inside=%b, expected 0", bus.InsideRectangle);
        end
`else
        set_pixel(294, 470);
        checks++;
        if (bus.InsideRectangle !== 1'b1 || bus.offsetY !== 11'd0) begin
            errors++;
            $display("[TB] FAIL noskip_top470: inside=%b oy=%0d, expected 1/0",
                     bus.InsideRectangle, bus.offsetY);
        end
        set_pixel(294, 400);
        checks++;
        if (bus.InsideRectangle !== 1'b0) begin
            errors++;
            $display("[TB] FAIL noskip_rest400: inside=%b, expected 0", bus.InsideRectangle);
        end
`endif
    endtask

    task automatic test_show_drop();
        bus.show = 1'b0;
        tick();
        checks++;
        if (bus.promptActive !== 1'b0) begin
            errors++;
            $display("[TB] FAIL show_drop_hide: active=%b, expected 0", bus.promptActive);
        end
        bus.show = 1'b1;
        frame_pulse(4);
        set_pixel(294, 474);
        checks++;
        if (bus.InsideRectangle !== 1'b1) begin
            errors++;
            $display("[TB] FAIL drop_setup474: inside=%b, expected 1", bus.InsideRectangle);
        end
        bus.show = 1'b0;
        bus.startOfFrame = 1'b1;
        tick();
        bus.startOfFrame = 1'b0;
        checks++;
        if (bus.promptActive !== 1'b0 || bus.enterAck !== 1'b0) begin
            errors++;
            $display("[TB] FAIL drop_sof_state: active=%b ack=%b, expected 0/0",
                     bus.promptActive, bus.enterAck);
        end
        tick();
        checks++;
        if (bus.InsideRectangle !== 1'b0 || bus.offsetX !== 11'd0 || bus.offsetY !== 11'd0) begin
            errors++;
            $display("[TB] FAIL drop_outputs: inside=%b ox=%0d oy=%0d, expected 0/0/0",
                     bus.InsideRectangle, bus.offsetX, bus.offsetY);
        end
        bus.show = 1'b1;
        frame_pulse(1);
        checks++;
        if (bus.InsideRectangle !== 1'b0 || bus.promptActive !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reenter_top480: inside=%b active=%b, expected 0/1",
                     bus.InsideRectangle, bus.promptActive);
        end
    endtask

    task automatic test_enter_and_drop();
        frame_pulse(40);
        set_pixel(294, 400);
        checks++;
        if (bus.InsideRectangle !== 1'b1) begin
            errors++;
            $display("[TB] FAIL both_setup: inside=%b, expected 1", bus.InsideRectangle);
        end
        bus.enterPressed = 1'b1;
        bus.show = 1'b0;
        tick();
        bus.enterPressed = 1'b0;
        checks++;
        if (bus.enterAck !== 1'b1 || bus.promptActive !== 1'b0) begin
            errors++;
            $display("[TB] FAIL both_ack: ack=%b active=%b, expected 1/0",
                     bus.enterAck, bus.promptActive);
        end
        tick();
        checks++;
        if (bus.enterAck !== 1'b0 || bus.InsideRectangle !== 1'b0) begin
            errors++;
            $display("[TB] FAIL both_after: ack=%b inside=%b, expected 0/0",
                     bus.enterAck, bus.InsideRectangle);
        end
    endtask

    task automatic test_reset_mid();
        bus.show = 1'b1;
        frame_pulse(41);
        set_pixel(300, 405);
        checks++;
        if (bus.InsideRectangle !== 1'b1 || bus.offsetX !== 11'd6) begin
            errors++;
            $display("[TB] FAIL midreset_setup: inside=%b ox=%0d, expected 1/6",
                     bus.InsideRectangle, bus.offsetX);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.InsideRectangle !== 1'b0 || bus.offsetX !== 11'd0 || bus.offsetY !== 11'd0
            || bus.promptActive !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_async: inside=%b ox=%0d oy=%0d active=%b, expected 0/0/0/0",
                     bus.InsideRectangle, bus.offsetX, bus.offsetY, bus.promptActive);
        end
        tick();
        reset = 1'b0;
        set_pixel(300, 405);
        tick();
        checks++;
        if (bus.InsideRectangle !== 1'b0 || bus.promptActive !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_after: inside=%b active=%b, expected 0/0",
                     bus.InsideRectangle, bus.promptActive);
        end
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        reset            = 1'b1;
        bus.pixelX       = '0;
        bus.pixelY       = '0;
        bus.startOfFrame = 1'b0;
        bus.show         = 1'b0;
        bus.enterPressed = 1'b0;
        test_reset();
        test_slide();
        test_blink();
        test_enter_blink_off();
        test_enter_slide();
        test_show_drop();
        test_enter_and_drop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
